md_issue_ctrl: RTL and testbench
================================

# md_issue_ctrl

Initiator-side controller for the multiply/divide unit in the E stage. It accepts MD-class operations from the pipeline, drives the MD unit's op, operand and start inputs, and tracks the unit's busy flag. It raises a stall to the pipeline whenever an operation cannot be accepted. HI/LO reads are held off until the unit and any buffered operation have fully drained.

## Interface
Parameters:
- `WIDTH`, default 32: operand width of D1/D2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req_valid`  in  1  an MD-class instruction is present in E this cycle.
- `req_op`  in  4  MD op code (md_pkg encoding).
- `req_d1`  in  WIDTH  rs operand (forwarded).
- `req_d2`  in  WIDTH  rt operand (forwarded).
- `flush`  in  1  discard the buffered (not yet launched) op; no effect on an in-flight op.
- `stall`  out  1  request not accepted this cycle; the pipeline holds E and earlier stages.
- `md_op`  out  4  op presented to the MD unit.
- `md_d1`  out  WIDTH  operand 1 to the MD unit.
- `md_d2`  out  WIDTH  operand 2 to the MD unit.
- `md_start`  out  1  one-cycle launch pulse for MULT/MULTU/DIV/DIVU.
- `md_busy`  in  1  MD unit busy flag; registered, high from the cycle after `md_start`.

## Operation
- Op classes:
  - start ops: MULT=1, MULTU=2, DIV=3, DIVU=4.
  - write ops: MTHI=5, MTLO=6.
  - read ops: MFHI=7, MFLO=8.
  - NONE=0 and 9..15 are non-MD and are always accepted with no action.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE + accepted start op → LAUNCH. The op and operands are registered onto `md_*`.
  - LAUNCH (`md_start`=1 for exactly this cycle) → WAIT, unconditionally.
  - WAIT: if `md_busy`=1, stay. If `md_busy`=0 with the skid buffer full → LAUNCH with the buffered op. If `md_busy`=0 with the buffer empty → IDLE.
- Acceptance (`stall = req_valid & ~accept`):
  - start op: accepted in IDLE. With MD_SKID_EN it is also accepted in LAUNCH/WAIT when the skid buffer is empty.
  - write op: accepted only in IDLE with the skid buffer empty. It drives `md_op` with `md_d1=req_d1` for one cycle and `md_start`=0; the FSM stays in IDLE.
  - read op: accepted only in IDLE with the skid buffer empty. No MD drive; the pipeline reads HI/LO directly.
- Idle outputs: `md_op`=NONE, `md_start`=0, `md_d1`/`md_d2` hold their last value.
- `flush` clears the skid buffer in the same edge. It overrides a simultaneous skid load.
- A simultaneous `flush` and WAIT-exit sends the FSM to IDLE, not LAUNCH.
- No arithmetic is performed. Operands pass through unmodified at WIDTH bits.

## Timing
- Reset values: `stall`=0 (combinational; evaluates to 0 when `req_valid`=0), `md_op`=0, `md_d1`=0, `md_d2`=0, `md_start`=0. FSM=IDLE, skid empty.
- A start op accepted at edge T: `md_start`=1 and `md_op`/`md_d*` are valid during cycle T+1.
- The MD unit asserts busy from T+2. The LAUNCH state covers the cycle-T+1 gap in which `md_busy` is still 0.
- Write op accepted at edge T: `md_op` is valid during T+1 only.
- The earliest cycle a read op can be accepted is the first cycle the FSM is IDLE after `md_busy` falls, i.e. one cycle after HI/LO are committed.
- Back-to-back start ops (skid enabled): the second launches in the cycle after `md_busy` is first sampled low.
- Reset mid-operation returns to IDLE immediately. The MD unit shares `reset` and aborts too.

## Configuration
- `MD_SKID_EN` defined: a 1-entry skid buffer (op, d1, d2, valid) lets one start op be accepted while another is in flight.
- `MD_SKID_EN` undefined: no buffer. Every MD-class op stalls while FSM≠IDLE, and `flush` has no effect.

## Structure
- Shared package `md_pkg`:
  - MD op-code localparams (NONE..MFLO).
  - state encoding (IDLE=0, LAUNCH=1, WAIT=2).
  - op-class helper functions `is_start_op`, `is_write_op`, `is_read_op`.
- Optional sub-module `md_skid_buf`: 1-entry load/pop/flush register, instantiated under `MD_SKID_EN`.

## Test plan
- Reset: assert `reset` mid-WAIT → all outputs 0 and FSM IDLE asynchronously; `stall`=0 with `req_valid`=0.
- MULT d1=7, d2=-3 in IDLE → no stall. Next cycle `md_start`=1, `md_op`=1, `md_d1`=7, `md_d2`=0xFFFFFFFD. `md_start` is 0 the cycle after.
- MULT then MFLO while `md_busy` is high for 5 cycles → MFLO stalls every cycle until the first IDLE cycle after busy falls, then is accepted.
- MD_SKID_EN: DIV then MULTU issued back-to-back → no stall on MULTU. MULTU launches the cycle after `md_busy` is sampled low. A third start op stalls while the buffer is full.
- MD_SKID_EN: DIVU buffered, `flush` pulsed during WAIT → busy falls, FSM goes to IDLE, and no second `md_start` occurs.
- MTHI d1=0x1234 in IDLE → `md_op`=5, `md_d1`=0x1234 for one cycle, `md_start`=0. The same MTHI during WAIT stalls.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue path: op codes, FSM
// state encoding and op-class helpers.
package md_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } md_state_e;

  function automatic logic is_start_op(input logic [MD_OP_W-1:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_write_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  function automatic logic is_read_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

endpackage

// File: rtl/md_skid_buf.sv
// One-entry holding register for a start op accepted while the MD unit is
// occupied. Flush wins over a same-edge load.
module md_skid_buf
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [MD_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]   d1_i,
  input  logic [WIDTH-1:0]   d2_i,
  output logic               vld_o,
  output logic [MD_OP_W-1:0] op_o,
  output logic [WIDTH-1:0]   d1_o,
  output logic [WIDTH-1:0]   d2_o
);

  logic               vld_q, vld_d;
  logic [MD_OP_W-1:0] op_q;
  logic [WIDTH-1:0]   d1_q, d2_q;

  always_comb begin
    vld_d = vld_q;
    if (pop_i)   vld_d = 1'b0;
    if (load_i)  vld_d = 1'b1;
    if (flush_i) vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_d;
  end

  // Payload is only meaningful while vld_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_i) begin
      op_q <= op_i;
      d1_q <= d1_i;
      d2_q <= d2_i;
    end
  end

  assign vld_o = vld_q;
  assign op_o  = op_q;
  assign d1_o  = d1_q;
  assign d2_o  = d2_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue controller for the E-stage multiply/divide unit. Define MD_SKID_EN
// to add a one-entry skid buffer so a start op can queue behind an in-flight one.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [MD_OP_W-1:0] req_op,
  input  logic [WIDTH-1:0]   req_d1,
  input  logic [WIDTH-1:0]   req_d2,
  input  logic               flush,
  output logic               stall,
  output logic [MD_OP_W-1:0] md_op,
  output logic [WIDTH-1:0]   md_d1,
  output logic [WIDTH-1:0]   md_d2,
  output logic               md_start,
  input  logic               md_busy
);

`ifdef MD_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  md_state_e          state_q;
  logic [MD_OP_W-1:0] md_op_q;
  logic [WIDTH-1:0]   md_d1_q, md_d2_q;
  logic               md_start_q;

  logic               skid_vld;
  logic [MD_OP_W-1:0] skid_op;
  logic [WIDTH-1:0]   skid_d1, skid_d2;

  logic req_start, req_write, req_read;
  logic in_idle, wait_exit, accept, take_start;
  logic launch_skid, launch_req_wait;

  assign req_start = is_start_op(req_op);
  assign req_write = is_write_op(req_op);
  assign req_read  = is_read_op(req_op);
  assign in_idle   = (state_q == ST_IDLE);
  assign wait_exit = (state_q == ST_WAIT) && !md_busy;

  always_comb begin
    accept = 1'b1;
    if (req_start)
      accept = in_idle || (SKID_EN && !skid_vld);
    else if (req_write || req_read)
      accept = in_idle && !skid_vld;
  end

  assign stall      = req_valid && !accept;
  assign take_start = req_valid && req_start && accept;

  // A start op arriving on the WAIT-exit cycle with nothing buffered launches
  // directly; buffering it would strand it once the FSM drops to IDLE.
  assign launch_skid     = wait_exit && skid_vld && !flush;
  assign launch_req_wait = wait_exit && !skid_vld && take_start && !flush;

`ifdef MD_SKID_EN
  logic skid_load;
  assign skid_load = take_start && !in_idle && !wait_exit;

  md_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load_i (skid_load),
    .pop_i  (wait_exit),
    .flush_i(flush),
    .op_i   (req_op),
    .d1_i   (req_d1),
    .d2_i   (req_d2),
    .vld_o  (skid_vld),
    .op_o   (skid_op),
    .d1_o   (skid_d1),
    .d2_o   (skid_d2)
  );
`else
  assign skid_vld = 1'b0;
  assign skid_op  = MD_NONE;
  assign skid_d1  = '0;
  assign skid_d2  = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      md_op_q    <= MD_NONE;
      md_d1_q    <= '0;
      md_d2_q    <= '0;
      md_start_q <= 1'b0;
    end else begin
      md_op_q    <= MD_NONE;
      md_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take_start) begin
            state_q    <= ST_LAUNCH;
            md_op_q    <= req_op;
            md_d1_q    <= req_d1;
            md_d2_q    <= req_d2;
            md_start_q <= 1'b1;
          end else if (req_valid && req_write && accept) begin
            md_op_q <= req_op;
            md_d1_q <= req_d1;
          end
        end
        ST_LAUNCH: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (launch_skid) begin
            state_q    <= ST_LAUNCH;
            md_op_q    <= skid_op;
            md_d1_q    <= skid_d1;
            md_d2_q    <= skid_d2;
            md_start_q <= 1'b1;
          end else if (launch_req_wait) begin
            state_q    <= ST_LAUNCH;
            md_op_q    <= req_op;
            md_d1_q    <= req_d1;
            md_d2_q    <= req_d2;
            md_start_q <= 1'b1;
          end else if (!md_busy) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign md_op    = md_op_q;
  assign md_d1    = md_d1_q;
  assign md_d2    = md_d2_q;
  assign md_start = md_start_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small MD-unit busy model.
module tb_md_issue_ctrl;
  import md_pkg::*;

  localparam int WIDTH    = 32;
  localparam int BUSY_LEN = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid;
  logic [MD_OP_W-1:0] req_op;
  logic [WIDTH-1:0]   req_d1, req_d2;
  logic               flush;
  logic               stall;
  logic [MD_OP_W-1:0] md_op;
  logic [WIDTH-1:0]   md_d1, md_d2;
  logic               md_start;
  logic               md_busy;

  int busy_cnt;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  md_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_d1   (req_d1),
    .req_d2   (req_d2),
    .flush    (flush),
    .stall    (stall),
    .md_op    (md_op),
    .md_d1    (md_d1),
    .md_d2    (md_d2),
    .md_start (md_start),
    .md_busy  (md_busy)
  );

  // MD unit: busy from the cycle after md_start for BUSY_LEN cycles.
  always @(posedge clk or posedge reset) begin
    if (reset)              busy_cnt <= 0;
    else if (md_start)      busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign md_busy = (busy_cnt != 0);

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_op    = MD_NONE;
    req_d1    = '0;
    req_d2    = '0;
    flush     = 1'b0;
  endtask

  task automatic drive(input logic [MD_OP_W-1:0] op, input logic [WIDTH-1:0] d1,
                       input logic [WIDTH-1:0] d2);
    req_valid = 1'b1;
    req_op    = op;
    req_d1    = d1;
    req_d2    = d2;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (md_op !== 4'd0) begin n_fail++; $display("FAIL rst_md_op got %0h exp 0", md_op); end
    n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL rst_md_start got %0b exp 0", md_start); end
    n_checks++; if (md_d1 !== 32'd0) begin n_fail++; $display("FAIL rst_md_d1 got %0h exp 0", md_d1); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b exp 0", stall); end
    reset = 1'b0;
    // Launch a MULT, then hit reset while in WAIT.
    @(negedge clk); drive(MD_MULT, 32'd5, 32'd6);
    @(negedge clk); idle_inputs();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL midwait_state got %0d exp 0", dut.state_q); end
    n_checks++; if (md_op !== 4'd0) begin n_fail++; $display("FAIL midwait_md_op got %0h exp 0", md_op); end
    n_checks++; if (md_d1 !== 32'd0) begin n_fail++; $display("FAIL midwait_md_d1 got %0h exp 0", md_d1); end
    n_checks++; if (md_d2 !== 32'd0) begin n_fail++; $display("FAIL midwait_md_d2 got %0h exp 0", md_d2); end
    n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL midwait_md_start got %0b exp 0", md_start); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midwait_stall got %0b exp 0", stall); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mult_launch();
    @(negedge clk); drive(MD_MULT, 32'd7, 32'hFFFF_FFFD); #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mult_stall got %0b exp 0", stall); end
    @(posedge clk); #1;
    n_checks++; if (md_start !== 1'b1) begin n_fail++; $display("FAIL mult_start got %0b exp 1", md_start); end
    n_checks++; if (md_op !== MD_MULT) begin n_fail++; $display("FAIL mult_op got %0h exp 1", md_op); end
    n_checks++; if (md_d1 !== 32'd7) begin n_fail++; $display("FAIL mult_d1 got %0h exp 7", md_d1); end
    n_checks++; if (md_d2 !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL mult_d2 got %0h exp fffffffd", md_d2); end
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL mult_start_drop got %0b exp 0", md_start); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_read_holdoff();
    int  stalls;
    bit  acc;
    stalls = 0;
    acc    = 1'b0;
    @(negedge clk); drive(MD_MULT, 32'd2, 32'd3);
    @(negedge clk); drive(MD_MFLO, 32'd0, 32'd0);
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (stall) stalls++;
      else       acc = 1'b1;
      if (!acc) @(negedge clk);
    end
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL mflo_accept got %0b exp 1 (timeout)", acc); end
    // LAUNCH + five busy cycles + the WAIT cycle that samples busy low.
    n_checks++; if (stalls != 7) begin n_fail++; $display("FAIL mflo_stall_cycles got %0d exp 7", stalls); end
    @(posedge clk); #1;
    n_checks++; if (md_op !== MD_NONE) begin n_fail++; $display("FAIL mflo_md_op got %0h exp 0", md_op); end
    n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL mflo_md_start got %0b exp 0", md_start); end
    @(negedge clk); idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    @(negedge clk); drive(MD_MTHI, 32'h1234, 32'h55); #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall got %0b exp 0", stall); end
    @(posedge clk); #1;
    n_checks++; if (md_op !== MD_MTHI) begin n_fail++; $display("FAIL mthi_op got %0h exp 5", md_op); end
    n_checks++; if (md_d1 !== 32'h1234) begin n_fail++; $display("FAIL mthi_d1 got %0h exp 1234", md_d1); end
    n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL mthi_start got %0b exp 0", md_start); end
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    n_checks++; if (md_op !== MD_NONE) begin n_fail++; $display("FAIL mthi_op_drop got %0h exp 0", md_op); end
    // Same write while the unit is busy.
    @(negedge clk); drive(MD_MULT, 32'd1, 32'd1);
    @(negedge clk); idle_inputs();
    @(negedge clk); drive(MD_MTHI, 32'h1234, 32'h0); #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mthi_wait_stall got %0b exp 1", stall); end
    req_op = MD_MFHI; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mfhi_wait_stall got %0b exp 1", stall); end
    req_op = 4'd9; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nonmd_wait_stall got %0b exp 0", stall); end
    idle_inputs();
    repeat (10) @(negedge clk);
  endtask

`ifdef MD_SKID_EN
  task automatic test_back_to_back();
    int cyc;
    cyc = 0;
    @(negedge clk); drive(MD_DIV, 32'd100, 32'd7);
    @(negedge clk); drive(MD_MULTU, 32'hAAAA_0000, 32'h1234_5678); #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_multu_stall got %0b exp 0", stall); end
    @(negedge clk); drive(MD_MULT, 32'd9, 32'd9); #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_third_stall got %0b exp 1", stall); end
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (md_start) break;
    end
    n_checks++; if (cyc != 6) begin n_fail++; $display("FAIL b2b_launch_cycle got %0d exp 6", cyc); end
    n_checks++; if (md_op !== MD_MULTU) begin n_fail++; $display("FAIL b2b_op got %0h exp 2", md_op); end
    n_checks++; if (md_d1 !== 32'hAAAA_0000) begin n_fail++; $display("FAIL b2b_d1 got %0h exp aaaa0000", md_d1); end
    n_checks++; if (md_d2 !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_d2 got %0h exp 12345678", md_d2); end
    @(posedge clk); #1;
    n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL b2b_start_drop got %0b exp 0", md_start); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_flush();
    int starts;
    int fl_cyc [2] = '{3, 7};
    for (int k = 0; k < 2; k++) begin
      starts = 0;
      @(negedge clk); drive(MD_MULT, 32'd3, 32'd4);
      @(negedge clk); drive(MD_DIVU, 32'd8, 32'd2); #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_divu_stall got %0b exp 0", stall); end
      idle_inputs();
      repeat (fl_cyc[k] - 1) @(negedge clk);
      flush = 1'b1;
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        flush = 1'b0;
        if (md_start) starts++;
      end
      n_checks++; if (starts != 0) begin n_fail++; $display("FAIL flush_starts_c%0d got %0d exp 0", fl_cyc[k], starts); end
      n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL flush_state_c%0d got %0d exp 0", fl_cyc[k], dut.state_q); end
      @(negedge clk); drive(MD_MFHI, 32'd0, 32'd0); #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_mfhi_stall got %0b exp 0", stall); end
      @(negedge clk); idle_inputs();
    end
  endtask
`else
  task automatic test_back_to_back();
    @(negedge clk); drive(MD_DIV, 32'd100, 32'd7);
    @(negedge clk); drive(MD_MULTU, 32'hAAAA_0000, 32'h1234_5678); #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL noskid_multu_stall got %0b exp 1", stall); end
    @(negedge clk); #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL noskid_multu_wait_stall got %0b exp 1", stall); end
    idle_inputs();
    repeat (10) @(negedge clk);
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_mult_launch();
    test_read_holdoff();
    test_write();
    test_back_to_back();
`ifdef MD_SKID_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
